// File: rtl/command_interpreter.sv
// Host command interpreter: decodes 32-bit UART command words, drives core
// clock/reset/pulse controls and a handshaked memory bus with timeout and
// burst reads, and sends replies back through the UART TX FIFO.
module command_interpreter #(
    parameter int          CLK_FREQ           = 25000000,
    parameter int          PULSE_CONTROL_BITS = 32,
    parameter int          BUS_WIDTH          = 32,
    parameter logic [31:0] ID                 = 32'h0000_0002,
    parameter int          RESET_CLK_CYCLES   = 20,
    parameter logic [31:0] DEFAULT_TIMEOUT    = 32'd360,
    parameter logic [31:0] ERR_CODE           = 32'hDEAD_BEEF
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          uart_rx_empty,
    input  logic                          uart_tx_empty,
    output logic                          uart_read,
    output logic                          uart_write,
    input  logic                          uart_response,
    input  logic [31:0]                   uart_read_data,
    output logic [31:0]                   uart_write_data,
    output logic                          core_clk_enable,
    output logic                          core_reset,
    output logic [PULSE_CONTROL_BITS-1:0] num_of_cycles_to_pulse,
    output logic                          write_pulse,
    input  logic                          memory_response,
    output logic                          memory_read,
    output logic                          memory_write,
    output logic                          memory_mux_selector,
    output logic [7:0]                    memory_page_number,
    output logic [BUS_WIDTH-1:0]          write_data,
    output logic [BUS_WIDTH-1:0]          address,
    input  logic [BUS_WIDTH-1:0]          read_data
);

    typedef enum logic [3:0] {
        IDLE, FETCH, WAIT_RX, DECODE, EXEC, FETCH_DATA,
        MEM_WAIT, RESET_HOLD, SEND, WAIT_TX
    } state_t;

    localparam logic [7:0] OP_PING = "p", OP_PULSE = "C", OP_STOP = "S",
                           OP_GO = "G", OP_RST = "R", OP_UPPER = "U",
                           OP_LOWER = "l", OP_ADD = "A", OP_WR2 = "W",
                           OP_LOAD = "L", OP_WACC = "w", OP_SACC = "s",
                           OP_RACC = "r", OP_BURST = "B", OP_TMO = "T",
                           OP_PAGE = "P";

    localparam logic [BUS_WIDTH-1:0] HI24 = BUS_WIDTH'(32'hFFFF_FF00);
    localparam logic [BUS_WIDTH-1:0] LO8  = BUS_WIDTH'(32'h0000_00FF);
    localparam logic [BUS_WIDTH-1:0] STEP = BUS_WIDTH'(32'd4);

    state_t                          state_q, state_d;
    logic [31:0]                     cmd_q, data_q, timeout_q, wait_cnt_q, hold_cnt_q;
    logic                            data_phase_q, rd_q, burst_q;
    logic [23:0]                     burst_left_q;
    logic [BUS_WIDTH-1:0]            acc_q, address_q, write_data_q;
    logic                            uart_read_q, uart_write_q, write_pulse_q;
    logic                            clk_en_q, core_reset_q, mem_rd_q, mem_wr_q, mux_q;
    logic [31:0]                     tx_data_q;
    logic [PULSE_CONTROL_BITS-1:0]   pulse_q;
    logic [7:0]                      page_q;

    logic [7:0]  opcode;
    logic [23:0] n;
    logic [31:0] rd32;
    logic        tmo_hit;

    assign opcode  = cmd_q[7:0];
    assign n       = cmd_q[31:8];
    assign rd32    = 32'(read_data);
    // The wait counter starts at 0 on the first request cycle, so the request
    // is held for exactly timeout_q cycles before it is dropped.
    assign tmo_hit = (timeout_q != 32'd0) && (wait_cnt_q + 32'd1 == timeout_q);

    assign uart_read              = uart_read_q;
    assign uart_write             = uart_write_q;
    assign uart_write_data        = tx_data_q;
    assign core_clk_enable        = clk_en_q;
    assign core_reset             = core_reset_q;
    assign num_of_cycles_to_pulse = pulse_q;
    assign write_pulse            = write_pulse_q;
    assign memory_read            = mem_rd_q;
    assign memory_write           = mem_wr_q;
    assign memory_mux_selector    = mux_q;
    assign memory_page_number     = page_q;
    assign write_data             = write_data_q;
    assign address                = address_q;

    // Next-state selection.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:       if (!uart_rx_empty) state_d = FETCH;
            FETCH:      state_d = WAIT_RX;
            WAIT_RX:    if (uart_response) state_d = data_phase_q ? EXEC : DECODE;
            DECODE: begin
                case (opcode)
                    OP_PING:                             state_d = SEND;
                    OP_PULSE, OP_STOP, OP_GO, OP_UPPER,
                    OP_LOWER, OP_ADD, OP_TMO, OP_PAGE:   state_d = IDLE;
                    OP_RST:                              state_d = RESET_HOLD;
                    OP_WR2:                              state_d = FETCH_DATA;
                    OP_LOAD, OP_WACC, OP_SACC, OP_RACC:  state_d = MEM_WAIT;
                    OP_BURST:                            state_d = (n == 24'd0) ? IDLE : MEM_WAIT;
                    default:                             state_d = SEND;
                endcase
            end
            EXEC:       state_d = MEM_WAIT;
            FETCH_DATA: if (!uart_rx_empty) state_d = WAIT_RX;
            MEM_WAIT: begin
                if (memory_response) state_d = rd_q ? SEND : IDLE;
                else if (tmo_hit)    state_d = SEND;
            end
            RESET_HOLD: if (hold_cnt_q == 32'(RESET_CLK_CYCLES - 1)) state_d = IDLE;
            SEND:       if (uart_tx_empty) state_d = WAIT_TX;
            WAIT_TX:    if (uart_response) state_d = (burst_left_q != 24'd0) ? MEM_WAIT : IDLE;
            default:    state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Datapath and registered outputs; strobes default low so each is one cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cmd_q <= '0; data_q <= '0; data_phase_q <= 1'b0;
            timeout_q <= DEFAULT_TIMEOUT; wait_cnt_q <= '0; hold_cnt_q <= '0;
            rd_q <= 1'b0; burst_q <= 1'b0; burst_left_q <= '0;
            acc_q <= '0; address_q <= '0; write_data_q <= '0;
            uart_read_q <= 1'b0; uart_write_q <= 1'b0; write_pulse_q <= 1'b0;
            clk_en_q <= 1'b0; core_reset_q <= 1'b0;
            mem_rd_q <= 1'b0; mem_wr_q <= 1'b0; mux_q <= 1'b1;
            tx_data_q <= '0; pulse_q <= '0; page_q <= '0;
        end else begin
            uart_read_q   <= 1'b0;
            uart_write_q  <= 1'b0;
            write_pulse_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    data_phase_q <= 1'b0;
                    if (!uart_rx_empty) uart_read_q <= 1'b1;
                end
                WAIT_RX: if (uart_response) begin
                    if (data_phase_q) data_q <= uart_read_data;
                    else              cmd_q  <= uart_read_data;
                end
                DECODE: begin
                    case (opcode)
                        OP_PING:  tx_data_q <= ID;
                        OP_PULSE: begin pulse_q <= PULSE_CONTROL_BITS'(n); write_pulse_q <= 1'b1; end
                        OP_STOP:  clk_en_q <= 1'b0;
                        OP_GO:    clk_en_q <= 1'b1;
                        OP_RST:   begin core_reset_q <= 1'b1; hold_cnt_q <= '0; end
                        OP_UPPER: acc_q <= (acc_q & ~HI24) | BUS_WIDTH'({n, 8'h00});
                        OP_LOWER: acc_q <= (acc_q & ~LO8) | BUS_WIDTH'(n[7:0]);
                        OP_ADD:   acc_q <= acc_q + BUS_WIDTH'(n);
                        OP_TMO:   timeout_q <= 32'(n);
                        OP_PAGE:  page_q <= n[7:0];
                        OP_WR2:   ;
                        OP_LOAD, OP_RACC: begin
                            mem_rd_q <= 1'b1; rd_q <= 1'b1; burst_q <= 1'b0;
                            mux_q <= 1'b0; wait_cnt_q <= '0;
                            address_q <= (opcode == OP_LOAD) ? BUS_WIDTH'(n) : acc_q;
                        end
                        OP_WACC, OP_SACC: begin
                            mem_wr_q <= 1'b1; rd_q <= 1'b0; burst_q <= 1'b0;
                            mux_q <= 1'b0; wait_cnt_q <= '0;
                            address_q    <= (opcode == OP_WACC) ? BUS_WIDTH'(n) : acc_q;
                            write_data_q <= (opcode == OP_WACC) ? acc_q : BUS_WIDTH'(n);
                        end
                        OP_BURST: if (n != 24'd0) begin
                            mem_rd_q <= 1'b1; rd_q <= 1'b1; burst_q <= 1'b1;
                            mux_q <= 1'b0; wait_cnt_q <= '0;
                            address_q <= acc_q; burst_left_q <= n - 24'd1;
                        end
                        default:  tx_data_q <= ERR_CODE;
                    endcase
                end
                EXEC: begin
                    mem_wr_q <= 1'b1; rd_q <= 1'b0; burst_q <= 1'b0;
                    mux_q <= 1'b0; wait_cnt_q <= '0;
                    address_q <= BUS_WIDTH'(n); write_data_q <= BUS_WIDTH'(data_q);
                end
                FETCH_DATA: if (!uart_rx_empty) begin
                    uart_read_q <= 1'b1; data_phase_q <= 1'b1;
                end
                MEM_WAIT: begin
                    // A response in the timeout cycle takes priority over the timeout.
                    if (memory_response) begin
                        mem_rd_q <= 1'b0; mem_wr_q <= 1'b0; mux_q <= 1'b1;
                        if (rd_q) tx_data_q <= rd32;
                        if (rd_q && burst_q) acc_q <= acc_q + STEP;
                    end else if (tmo_hit) begin
                        mem_rd_q <= 1'b0; mem_wr_q <= 1'b0; mux_q <= 1'b1;
                        tx_data_q <= ERR_CODE; burst_left_q <= '0;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 32'd1;
                    end
                end
                RESET_HOLD: begin
                    hold_cnt_q <= hold_cnt_q + 32'd1;
                    if (hold_cnt_q == 32'(RESET_CLK_CYCLES - 1)) core_reset_q <= 1'b0;
                end
                SEND: if (uart_tx_empty) uart_write_q <= 1'b1;
                WAIT_TX: if (uart_response && burst_left_q != 24'd0) begin
                    burst_left_q <= burst_left_q - 24'd1;
                    mem_rd_q <= 1'b1; mux_q <= 1'b0; wait_cnt_q <= '0;
                    address_q <= acc_q;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_command_interpreter.sv
// Bench for command_interpreter: UART and memory behavioural models, with
// scoreboard queues for expected replies and expected memory requests.
module tb_command_interpreter;

    logic        clk = 1'b0;
    logic        reset;
    logic        uart_rx_empty, uart_tx_empty, uart_read, uart_write, uart_response;
    logic [31:0] uart_read_data, uart_write_data;
    logic        core_clk_enable, core_reset, write_pulse;
    logic [31:0] num_of_cycles_to_pulse;
    logic        memory_response, memory_read, memory_write, memory_mux_selector;
    logic [7:0]  memory_page_number;
    logic [31:0] write_data, address, read_data;

    localparam logic [31:0] ID_W  = 32'h0000_0002;
    localparam logic [31:0] ERR_W = 32'hDEAD_BEEF;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wd;
        bit          wr;
    } mreq_t;

    logic [31:0] rx_q[$];
    logic [31:0] exp_tx[$];
    mreq_t       exp_mem[$];
    logic [31:0] mem [bit [31:0]];

    int errs = 0, checks = 0;
    int tx_cnt = 0, wp_cnt = 0, cr_cnt = 0;
    int ack_at = 1, req_len = 0, last_len = 0;
    bit req_act = 1'b0, rsp_pend = 1'b0;
    logic [31:0] rsp_data, cur_addr, cur_wd;

    command_interpreter dut (
        .clk(clk), .reset(reset),
        .uart_rx_empty(uart_rx_empty), .uart_tx_empty(uart_tx_empty),
        .uart_read(uart_read), .uart_write(uart_write),
        .uart_response(uart_response), .uart_read_data(uart_read_data),
        .uart_write_data(uart_write_data),
        .core_clk_enable(core_clk_enable), .core_reset(core_reset),
        .num_of_cycles_to_pulse(num_of_cycles_to_pulse), .write_pulse(write_pulse),
        .memory_response(memory_response), .memory_read(memory_read),
        .memory_write(memory_write), .memory_mux_selector(memory_mux_selector),
        .memory_page_number(memory_page_number),
        .write_data(write_data), .address(address), .read_data(read_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (!ok) begin
            errs++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // UART FIFO model plus reply scoreboard monitor.
    always @(negedge clk) begin
        uart_response  = 1'b0;
        uart_read_data = 32'd0;
        if (rsp_pend) begin
            uart_response  = 1'b1;
            uart_read_data = rsp_data;
            rsp_pend       = 1'b0;
        end
        if (uart_read) begin
            rsp_pend = 1'b1;
            rsp_data = (rx_q.size() != 0) ? rx_q.pop_front() : 32'd0;
        end
        if (uart_write) begin
            rsp_pend = 1'b1;
            rsp_data = 32'd0;
            tx_cnt++;
            if (exp_tx.size() == 0) chk(1'b0, "tx_unexpected", uart_write_data, 32'd0);
            else begin
                logic [31:0] e;
                e = exp_tx.pop_front();
                chk(uart_write_data == e, "tx_data", uart_write_data, e);
            end
        end
        if (write_pulse) wp_cnt++;
        if (core_reset)  cr_cnt++;
        uart_rx_empty = (rx_q.size() == 0);
    end

    // Memory model plus request scoreboard monitor.
    always @(negedge clk) begin
        if (memory_read || memory_write) begin
            if (!req_act) begin
                req_act  = 1'b1;
                req_len  = 0;
                cur_addr = address;
                cur_wd   = write_data;
                if (exp_mem.size() == 0) chk(1'b0, "mem_unexpected", address, 32'd0);
                else begin
                    mreq_t e;
                    e = exp_mem.pop_front();
                    chk(address == e.addr, "mem_addr", address, e.addr);
                    chk(memory_write == e.wr, "mem_kind", {31'd0, memory_write}, {31'd0, e.wr});
                    if (e.wr) chk(write_data == e.wd, "mem_wdata", write_data, e.wd);
                end
            end else begin
                chk(address == cur_addr && write_data == cur_wd, "mem_stable", address, cur_addr);
            end
            chk(memory_mux_selector == 1'b0, "mux_during_req", {31'd0, memory_mux_selector}, 32'd0);
            memory_response = (req_len == ack_at);
            read_data       = mem.exists(address) ? mem[address] : 32'd0;
            if (memory_response && memory_write) mem[address] = write_data;
            req_len++;
        end else begin
            memory_response = 1'b0;
            read_data       = 32'd0;
            if (req_act) begin
                req_act  = 1'b0;
                last_len = req_len;
                chk(memory_mux_selector == 1'b1, "mux_after_req", {31'd0, memory_mux_selector}, 32'd1);
            end
        end
    end

    task automatic push_mem(input logic [31:0] a, input logic [31:0] d, input bit wr);
        mreq_t m;
        m.addr = a; m.wd = d; m.wr = wr;
        exp_mem.push_back(m);
    endtask

    task automatic settle();
        int k = 0;
        while ((rx_q.size() != 0 || exp_tx.size() != 0 || exp_mem.size() != 0) && k < 400) begin
            @(negedge clk);
            k++;
        end
        chk(k < 400, "settle_budget", k, 400);
        repeat (30) @(negedge clk);
    endtask

    task automatic check_reset_values(input string tag);
        chk(!uart_read && !uart_write && !write_pulse, {tag, "_strobes"}, {29'd0, uart_read, uart_write, write_pulse}, 32'd0);
        chk(!core_clk_enable && !core_reset, {tag, "_core"}, {30'd0, core_clk_enable, core_reset}, 32'd0);
        chk(!memory_read && !memory_write, {tag, "_memreq"}, {30'd0, memory_read, memory_write}, 32'd0);
        chk(memory_mux_selector == 1'b1, {tag, "_mux"}, {31'd0, memory_mux_selector}, 32'd1);
        chk(address == 32'd0 && write_data == 32'd0, {tag, "_bus"}, address | write_data, 32'd0);
        chk(num_of_cycles_to_pulse == 32'd0, {tag, "_pulse"}, num_of_cycles_to_pulse, 32'd0);
        chk(memory_page_number == 8'd0, {tag, "_page"}, {24'd0, memory_page_number}, 32'd0);
        chk(uart_write_data == 32'd0, {tag, "_txdata"}, uart_write_data, 32'd0);
    endtask

    // Directed stimulus.
    initial begin
        int t0, k;
        reset = 1'b1; uart_tx_empty = 1'b1; uart_rx_empty = 1'b1;
        uart_response = 1'b0; uart_read_data = '0; memory_response = 1'b0; read_data = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_reset_values("reset");

        // PING
        t0 = tx_cnt; exp_tx.push_back(ID_W); rx_q.push_back(32'h0000_0070);
        settle();
        chk(tx_cnt - t0 == 1, "ping_count", tx_cnt - t0, 1);

        // Pulse count
        t0 = wp_cnt; rx_q.push_back(32'h0000_0A43);
        settle();
        chk(num_of_cycles_to_pulse == 32'd10, "pulse_value", num_of_cycles_to_pulse, 10);
        chk(wp_cnt - t0 == 1, "pulse_strobe", wp_cnt - t0, 1);

        // Core reset hold
        t0 = cr_cnt; rx_q.push_back(32'h0000_0052);
        settle();
        chk(cr_cnt - t0 == 20, "core_reset_len", cr_cnt - t0, 20);

        // Clock enable, page
        rx_q.push_back(32'h0000_0047); settle();
        chk(core_clk_enable == 1'b1, "clk_go", {31'd0, core_clk_enable}, 1);
        rx_q.push_back(32'h0000_0053); settle();
        chk(core_clk_enable == 1'b0, "clk_stop", {31'd0, core_clk_enable}, 0);
        rx_q.push_back(32'h0000_5A50); settle();
        chk(memory_page_number == 8'h5A, "page", {24'd0, memory_page_number}, 32'h5A);

        // Two-word write, ack on the 4th request cycle, no reply
        ack_at = 3; t0 = tx_cnt;
        push_mem(32'h40, 32'h1234_5678, 1'b1);
        rx_q.push_back(32'h0000_4057); rx_q.push_back(32'h1234_5678);
        settle();
        chk(tx_cnt == t0, "write_no_reply", tx_cnt - t0, 0);
        chk(last_len == 4, "write_req_len", last_len, 4);

        // Read back
        ack_at = 1;
        push_mem(32'h40, 32'd0, 1'b0); exp_tx.push_back(32'h1234_5678);
        rx_q.push_back(32'h0000_404C);
        settle();

        // acc = 0x1000, burst of 3 with zero-wait acks, then read at acc
        ack_at = 0;
        mem[32'h1000] = 32'hA; mem[32'h1004] = 32'hB; mem[32'h1008] = 32'hC; mem[32'h100C] = 32'h77;
        rx_q.push_back(32'h0000_1055);
        push_mem(32'h1000, 0, 1'b0); push_mem(32'h1004, 0, 1'b0); push_mem(32'h1008, 0, 1'b0);
        exp_tx.push_back(32'hA); exp_tx.push_back(32'hB); exp_tx.push_back(32'hC);
        rx_q.push_back(32'h0000_0342);
        settle();
        push_mem(32'h100C, 0, 1'b0); exp_tx.push_back(32'h77);
        rx_q.push_back(32'h0000_0072);
        settle();

        // Timeout 5: never ack -> error; ack on 5th cycle -> data
        rx_q.push_back(32'h0000_0554);
        ack_at = -1;
        push_mem(32'h80, 0, 1'b0); exp_tx.push_back(ERR_W);
        rx_q.push_back(32'h0000_804C);
        settle();
        chk(last_len == 5, "timeout_len", last_len, 5);
        ack_at = 4; mem[32'h80] = 32'h55;
        push_mem(32'h80, 0, 1'b0); exp_tx.push_back(32'h55);
        rx_q.push_back(32'h0000_804C);
        settle();
        chk(last_len == 5, "late_ack_len", last_len, 5);

        // Unknown opcode
        exp_tx.push_back(ERR_W); rx_q.push_back(32'h0000_007A);
        settle();

        // acc arithmetic and acc-based writes: acc 0x100C + 0x20 = 0x102C
        ack_at = 1;
        rx_q.push_back(32'h0000_2041);
        push_mem(32'h102C, 32'h99, 1'b1); rx_q.push_back(32'h0000_9973);
        settle();
        rx_q.push_back(32'h0000_106C);                         // acc = 0x1010
        push_mem(32'h50, 32'h1010, 1'b1); rx_q.push_back(32'h0000_5077);
        settle();

        // Reset mid-burst with timeout disabled and no ack
        rx_q.push_back(32'h0000_0054);
        ack_at = -1;
        push_mem(32'h1010, 0, 1'b0); rx_q.push_back(32'h0000_0242);
        k = 0;
        while (!memory_read && k < 200) begin @(negedge clk); k++; end
        chk(k < 200, "burst_start", k, 200);
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        #1 check_reset_values("async");
        repeat (2) @(negedge clk);
        exp_tx.delete(); rx_q.delete();
        reset = 1'b0;
        @(negedge clk);

        // Recovery
        ack_at = 1;
        exp_tx.push_back(ID_W); rx_q.push_back(32'h0000_0070);
        settle();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/command_interpreter.md
# command_interpreter

Parametrised host-command interpreter for the processor-CI controller. Sits between the UART FIFO pair and the core/memory control fabric. Decodes 32-bit UART command words and drives:
- core clock gating, pulse count and reset;
- a handshaked memory bus with timeout, including multi-word burst reads;
- replies to the host.

Successor to the single-shot interpreter: adds full memory handshakes, configurable timeout with error reply, burst read, two-word writes and explicit error codes.

## Interface
- CLK_FREQ, 25000000: informational, unused in logic.
- PULSE_CONTROL_BITS, 32: width of pulse-count output.
- BUS_WIDTH, 32: memory address/data width (≥ 24).
- ID, 32'h00000002: PING reply word.
- RESET_CLK_CYCLES, 20: core reset hold length.
- DEFAULT_TIMEOUT, 360: memory timeout after reset (0 = disabled).
- ERR_CODE, 32'hDEADBEEF: reply on timeout or unknown opcode.
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- uart_rx_empty  in  1  RX FIFO empty.
- uart_tx_empty  in  1  TX FIFO empty.
- uart_read  out  1  one-cycle RX pop request.
- uart_write  out  1  one-cycle TX push request.
- uart_response  in  1  UART op completed; RX data valid this cycle.
- uart_read_data  in  32  RX word.
- uart_write_data  out  32  TX word.
- core_clk_enable  out  1  free-run core clock enable (level).
- core_reset  out  1  core reset (level).
- num_of_cycles_to_pulse  out  PULSE_CONTROL_BITS  pulse count.
- write_pulse  out  1  one-cycle load strobe for pulse count.
- memory_response  in  1  memory ack.
- memory_read, memory_write  out  1  request, held until ack or timeout.
- memory_mux_selector  out  1  0 controller, 1 core.
- memory_page_number  out  8  page select.
- write_data, address  out  BUS_WIDTH  memory data/address.
- read_data  in  BUS_WIDTH  memory read data.

## Operation
- Command word: opcode = bits[7:0]; N = bits[31:8], zero-extended.
- Opcodes:
  - 'p' PING: reply ID.
  - 'C': num_of_cycles_to_pulse ← N, write_pulse for 1 cycle.
  - 'S': core_clk_enable ← 0.
  - 'G': core_clk_enable ← 1.
  - 'R': core_reset high for exactly RESET_CLK_CYCLES cycles.
  - 'U': acc[31:8] ← N.
  - 'l': acc[7:0] ← N[7:0].
  - 'A': acc ← acc + N, mod 2^BUS_WIDTH.
  - 'W': fetch a second UART word D; write D to address N.
  - 'L': read address N; reply.
  - 'w': write acc to address N.
  - 's': write N to address acc.
  - 'r': read address acc; reply.
  - 'B': burst read N words from acc; acc += 4 after each word; one reply per word; N = 0 gives no reply.
  - 'T': timeout ← N.
  - 'P': memory_page_number ← N[7:0].
  - Any other opcode: reply ERR_CODE.
- States: IDLE, FETCH, WAIT_RX, DECODE, EXEC, FETCH_DATA, MEM_WAIT, RESET_HOLD, SEND, WAIT_TX.
- IDLE → FETCH when !uart_rx_empty.
- FETCH: pulse uart_read, then → WAIT_RX.
- WAIT_RX: latch uart_read_data on uart_response, then → DECODE (or → EXEC after FETCH_DATA).
- MEM_WAIT: request held until memory_response.
  - Read: latch read_data, zero-extend or truncate to 32 bits, → SEND.
  - Write: → IDLE. Writes produce no reply.
  - If timeout ≠ 0 and the wait counter reaches timeout: drop request, reply ERR_CODE, abort any burst.
- SEND: wait for uart_tx_empty, pulse uart_write, → WAIT_TX.
- WAIT_TX → IDLE (or next burst word) on uart_response.
- memory_mux_selector is 0 from request issue until MEM_WAIT exits, otherwise 1.
- Reset values:
  - All strobes, core_clk_enable, core_reset: 0.
  - memory_mux_selector: 1.
  - acc, address, write_data, pulse count, page: 0.
  - timeout: DEFAULT_TIMEOUT.
  - uart_write_data: 0.
- Reset mid-operation aborts immediately. Requests drop in the same cycle reset asserts.

## Timing
- Strobes (uart_read, uart_write, write_pulse) are registered and exactly 1 cycle wide.
- Minimum latency, rx non-empty to uart_read: 1 cycle.
- DECODE is one cycle after uart_response.
- Register-only opcodes (C, S, G, U, l, A, T, P) take effect 2 cycles after uart_response, then return to IDLE.
- Memory request asserts 2 cycles after uart_response, with address/write_data stable for the whole request.
- memory_response on the first request cycle is accepted: a zero-wait transaction.
- Timeout fires on the cycle where the wait count equals timeout. memory_response in that same cycle wins.
- Burst: next request is issued 1 cycle after WAIT_TX completes.

## Test plan
- Reset, then 0x00000070 ('p'): exactly one uart_write with data ID. Check all reset values.
- 0x00000A43 ('C', N=10): num_of_cycles_to_pulse=10, single write_pulse. 'R': core_reset high exactly 20 cycles.
- 'W' N=0x40, data 0x12345678, ack after 3 cycles: address 0x40, write_data held, mux_selector 0 only during the request, no reply. Then 'L' N=0x40 returns 0x12345678.
- 'U' N=0x10 (acc=0x1000), then 'B' N=3 with memory returning 0xA, 0xB, 0xC: addresses 0x1000/0x1004/0x1008, three replies in order, final acc 0x100C.
- 'T' N=5, then 'L' with memory never acking: request drops after 5 wait cycles, reply ERR_CODE. Repeat with ack on the 5th cycle: real data wins.
- Opcode 0x7A: ERR_CODE reply. Reset asserted mid-burst: all outputs return to reset values asynchronously.
